// File: rtl/mem_port_arbiter.sv
// Two-port round-robin word arbiter onto a byte-wide synchronous RAM; each word is four big-endian beats.
// Optional alignment checking is compiled in with MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [31:0]           addr0,
    output logic                  ack0,
    output logic [31:0]           rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [31:0]           addr1,
    input  logic [31:0]           wdata1,
    output logic                  ack1,
    output logic [31:0]           rdata1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    logic                    port_q, port_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             shadow_q, shadow_d;
    logic                    last_grant_q, last_grant_d;
    logic [31:0]             rdata0_q, rdata0_d;
    logic [31:0]             rdata1_q, rdata1_d;
    logic                    grant1;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic                    err_q, err_d;
    logic                    misalign;
`endif

    // Only the low ADDR_WIDTH address bits reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_WIDTH], addr1[31:ADDR_WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            base_q       <= '0;
            wdata_q      <= 32'd0;
            shadow_q     <= 32'd0;
            last_grant_q <= 1'b1;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            port_q       <= port_d;
            we_q         <= we_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            shadow_q     <= shadow_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        port_d       = port_q;
        we_d         = we_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        shadow_d     = shadow_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        grant1       = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        err_d        = err_q;
        misalign     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Under contention the port that did not win last time is served.
                    grant1       = req1 && (!req0 || !last_grant_q);
                    port_d       = grant1;
                    last_grant_d = grant1;
                    base_d       = grant1 ? addr1[ADDR_WIDTH-1:0] : addr0[ADDR_WIDTH-1:0];
                    we_d         = grant1 && we1;
                    wdata_d      = wdata1;
                    beat_d       = 2'd0;
                    state_d      = XFER;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                    misalign     = grant1 ? (addr1[1:0] != 2'b00) : (addr0[1:0] != 2'b00);
                    err_d        = misalign;
                    if (misalign) begin
                        state_d = DONE;
                    end
`endif
                end
            end

            XFER: begin
                // RAM data lags the address by one cycle, so beat b returns byte b-1.
                if (!we_q) begin
                    case (beat_q)
                        2'd1:    shadow_d[31:24] = ram_rdata;
                        2'd2:    shadow_d[23:16] = ram_rdata;
                        2'd3:    shadow_d[15:8]  = ram_rdata;
                        default: shadow_d        = shadow_q;
                    endcase
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = we_q ? DONE : TAIL;
                end
            end

            TAIL: begin
                shadow_d[7:0] = ram_rdata;
                if (port_q) begin
                    rdata1_d = {shadow_q[31:8], ram_rdata};
                end else begin
                    rdata0_d = {shadow_q[31:8], ram_rdata};
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_wdata = 8'd0;
        if (state_q == XFER && we_q) begin
            case (beat_q)
                2'd0:    ram_wdata = wdata_q[31:24];
                2'd1:    ram_wdata = wdata_q[23:16];
                2'd2:    ram_wdata = wdata_q[15:8];
                default: ram_wdata = wdata_q[7:0];
            endcase
        end
    end

    assign ram_addr = (state_q == XFER) ? base_q + {{(ADDR_WIDTH-2){1'b0}}, beat_q} : '0;
    assign ram_we   = (state_q == XFER) && we_q;
    assign busy     = (state_q != IDLE);
    assign ack0     = (state_q == DONE) && !port_q;
    assign ack1     = (state_q == DONE) && port_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign err0 = ack0 && err_q;
    assign err1 = ack1 && err_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide synchronous RAM model.
// Honours MEM_ARB_ALIGN_CHECK_EN for the misaligned-request step.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req0;
    logic [31:0] addr0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        err0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        err1;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        busy;

    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;
    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .addr0     (addr0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .err0      (err0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .err1      (err1),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    initial begin
        logic [7:0]  wb [4];
        logic [15:0] wa [4];
        logic        seen_ack;

        reset = 1'b1; req0 = 1'b0; addr0 = 32'd0; req1 = 1'b0; we1 = 1'b0;
        addr1 = 32'd0; wdata1 = 32'd0; poke_en = 1'b0; poke_addr = 16'd0; poke_data = 8'd0;
        repeat (2) @(negedge clk);

        chk("rst_ack0", ack0, 0);      chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);  chk("rst_rdata1", rdata1, 0);
        chk("rst_err0", err0, 0);      chk("rst_err1", err1, 0);
        chk("rst_ram_addr", ram_addr, 0); chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0); chk("rst_busy", busy, 0);

        poke(16'h0010, 8'h11); poke(16'h0011, 8'h22); poke(16'h0012, 8'h33); poke(16'h0013, 8'h44);
        reset = 1'b0;
        @(negedge clk);

        // Port 0 read of 0x0010
        req0 = 1'b1; addr0 = 32'h0000_0010;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) addr0 = 32'h0000_0000;
            chk("rd0_addr", ram_addr, 32'h10 + b);
            chk("rd0_we", ram_we, 0);
            chk("rd0_busy", busy, 1);
        end
        @(negedge clk);
        chk("rd0_tail_noack", ack0, 0);
        chk("rd0_tail_busy", busy, 1);
        @(negedge clk);
        chk("rd0_ack", ack0, 1);
        chk("rd0_data", rdata0, 32'h1122_3344);
        chk("rd0_err", err0, 0);
        chk("rd0_done_busy", busy, 1);
        req0 = 1'b0;
        @(negedge clk);
        chk("rd0_idle_ack", ack0, 0);
        chk("rd0_idle_busy", busy, 0);
        chk("rd0_hold", rdata0, 32'h1122_3344);

        // Port 1 write of 0xDEADBEEF to 0x0020, then read back
        wb[0] = 8'hDE; wb[1] = 8'hAD; wb[2] = 8'hBE; wb[3] = 8'hEF;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0020; wdata1 = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin
                addr1 = 32'd0; wdata1 = 32'd0; we1 = 1'b0;
            end
            chk("wr1_addr", ram_addr, 32'h20 + b);
            chk("wr1_we", ram_we, 1);
            chk("wr1_wdata", ram_wdata, wb[b]);
        end
        @(negedge clk);
        chk("wr1_ack", ack1, 1);
        chk("wr1_err", err1, 0);
        chk("wr1_done_we", ram_we, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("wr1_mem", {mem[16'h20], mem[16'h21], mem[16'h22], mem[16'h23]}, 32'hDEAD_BEEF);

        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0020;
        repeat (5) @(negedge clk);
        chk("rd1_not_early", ack1, 0);
        @(negedge clk);
        chk("rd1_ack", ack1, 1);
        chk("rd1_data", rdata1, 32'hDEAD_BEEF);
        chk("rd1_rdata0_kept", rdata0, 32'h1122_3344);
        req1 = 1'b0;
        @(negedge clk);

        // Port 0 read wrapping past the top of the address space
        poke(16'hFFFE, 8'hA1); poke(16'hFFFF, 8'hB2); poke(16'h0000, 8'hC3); poke(16'h0001, 8'hD4);
        wa[0] = 16'hFFFE; wa[1] = 16'hFFFF; wa[2] = 16'h0000; wa[3] = 16'h0001;
        req0 = 1'b1; addr0 = 32'h0000_FFFE;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("wrap_addr", ram_addr, wa[b]);
        end
        repeat (2) @(negedge clk);
        chk("wrap_ack", ack0, 1);
        chk("wrap_data", rdata0, 32'hA1B2_C3D4);
        req0 = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of a write
        poke(16'h0040, 8'h00); poke(16'h0041, 8'h00); poke(16'h0042, 8'h00); poke(16'h0043, 8'h00);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        chk("abort_b2_addr", ram_addr, 32'h42);
        chk("abort_b2_we", ram_we, 1);
        chk("abort_b2_wdata", ram_wdata, 32'hF0);
        reset = 1'b1; req1 = 1'b0;
        #1;
        chk("abort_we", ram_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack1", ack1, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_wdata", ram_wdata, 0);
        chk("abort_rdata0", rdata0, 0);
        chk("abort_rdata1", rdata1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_ack = seen_ack | ack1 | busy;
        end
        chk("abort_no_ack", seen_ack, 0);
        chk("abort_mem40", mem[16'h40], 32'hCA);
        chk("abort_mem41", mem[16'h41], 32'hFE);
        chk("abort_mem42", mem[16'h42], 32'h00);
        chk("abort_mem43", mem[16'h43], 32'h00);

        // Contention straight after reset: port 0 first, then port 1
        req0 = 1'b1; addr0 = 32'h0000_0010;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0030; wdata1 = 32'h5566_7788;
        @(negedge clk);
        chk("cont_p0_addr", ram_addr, 32'h10);
        chk("cont_p0_we", ram_we, 0);
        repeat (5) @(negedge clk);
        chk("cont_ack0", ack0, 1);
        chk("cont_ack1_low", ack1, 0);
        chk("cont_rdata0", rdata0, 32'h1122_3344);
        req0 = 1'b0;
        @(negedge clk);
        chk("cont_idle", busy, 0);
        @(negedge clk);
        chk("cont_p1_addr", ram_addr, 32'h30);
        chk("cont_p1_we", ram_we, 1);
        chk("cont_p1_wdata", ram_wdata, 32'h55);
        repeat (4) @(negedge clk);
        chk("cont_ack1", ack1, 1);
        req1 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("rr_again_p0_addr", ram_addr, 32'h10);
        chk("rr_again_p0_we", ram_we, 0);
        repeat (5) @(negedge clk);
        chk("rr_again_ack0", ack0, 1);
        req0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("rr_again_ack1", ack1, 1);
        req1 = 1'b0;
        @(negedge clk);
        chk("cont_mem", {mem[16'h30], mem[16'h31], mem[16'h32], mem[16'h33]}, 32'h5566_7788);

        // Misaligned port 1 write at 0x0041
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0041; wdata1 = 32'h0102_0304;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        @(negedge clk);
        chk("mis_ack1", ack1, 1);
        chk("mis_err1", err1, 1);
        chk("mis_we", ram_we, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("mis_mem41", mem[16'h41], 32'hFE);
`else
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("mis_addr", ram_addr, 32'h41 + b);
            chk("mis_we", ram_we, 1);
        end
        @(negedge clk);
        chk("mis_ack1", ack1, 1);
        chk("mis_err1", err1, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("mis_mem", {mem[16'h41], mem[16'h42], mem[16'h43], mem[16'h44]}, 32'h0102_0304);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
